// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard and data-memory wait controller.
// Drives stage write enables, bubble flushes and stall/flush counters.
module pipeline_stall_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_hazard,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t state;
    logic [WAIT_W-1:0] wait_cnt;
    logic freeze;
    logic redirect;
    logic bubble;

    always_comb begin
        freeze = 1'b0;
        case (state)
            RUN:      freeze = mem_req & ~mem_ready;
            MEM_WAIT: freeze = ~mem_ready;
            default:  freeze = 1'b1;
        endcase
    end

    // A frozen pipeline must not act on hazards it cannot yet resolve.
    assign redirect = ~freeze & ex_branch_taken;
    assign bubble   = ~freeze & ~ex_branch_taken & load_use_hazard;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (bubble) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= ERROR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= ERROR;
                    mem_timeout <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((freeze || bubble) && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (redirect && flush_count != '1) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: two instances (small and default params)
// compared against a run-length model of memory waits.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, lu, br, mreq, mrdy;

    logic s_pc, s_ifid, s_idex, s_exmem, s_iff, s_idf, s_mwf, s_to;
    logic [3:0] s_stall, s_flush;
    logic b_pc, b_ifid, b_idex, b_exmem, b_iff, b_idf, b_mwf, b_to;
    logic [31:0] b_stall, b_flush;

    pipeline_stall_ctrl #(.MAX_WAIT(4), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .load_use_hazard(lu), .ex_branch_taken(br),
        .mem_req(mreq), .mem_ready(mrdy),
        .pc_write(s_pc), .if_id_write(s_ifid),
        .id_ex_write(s_idex), .ex_mem_write(s_exmem),
        .if_id_flush(s_iff), .id_ex_flush(s_idf),
        .mem_wb_flush(s_mwf), .mem_timeout(s_to),
        .stall_cycles(s_stall), .flush_count(s_flush)
    );

    pipeline_stall_ctrl u_big (
        .clk(clk), .rst_n(rst_n),
        .load_use_hazard(lu), .ex_branch_taken(br),
        .mem_req(mreq), .mem_ready(mrdy),
        .pc_write(b_pc), .if_id_write(b_ifid),
        .id_ex_write(b_idex), .ex_mem_write(b_exmem),
        .if_id_flush(b_iff), .id_ex_flush(b_idf),
        .mem_wb_flush(b_mwf), .mem_timeout(b_to),
        .stall_cycles(b_stall), .flush_count(b_flush)
    );

    logic [6:0] s_ctl, b_ctl;
    assign s_ctl = {s_pc, s_ifid, s_idex, s_exmem, s_iff, s_idf, s_mwf};
    assign b_ctl = {b_pc, b_ifid, b_idex, b_exmem, b_iff, b_idf, b_mwf};

    int errors = 0;
    int checks = 0;

    // Model: pend = frozen cycles so far in the current access
    int     pend [2];
    bit     err  [2];
    longint stl  [2];
    longint fl   [2];
    int     mw   [2] = '{4, 16};
    longint cmax [2] = '{64'd15, 64'hFFFF_FFFF};

    function automatic bit m_freeze(int k);
        return err[k] || ((mreq || pend[k] > 0) && !mrdy);
    endfunction

    function automatic logic [6:0] exp_ctl(int k);
        if (!rst_n) return 7'b0000_111;
        if (m_freeze(k)) return 7'b0000_001;
        if (br) return 7'b1111_110;
        if (lu) return 7'b0011_010;
        return 7'b1111_000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; err[k] = 0; stl[k] = 0; fl[k] = 0;
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            bit f;
            f = m_freeze(k);
            if ((f || (!br && lu)) && stl[k] < cmax[k]) stl[k]++;
            if (!f && br && fl[k] < cmax[k]) fl[k]++;
            if (!err[k]) begin
                if (f) begin
                    pend[k]++;
                    if (pend[k] == mw[k] + 1) err[k] = 1;
                end else begin
                    pend[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        chk("ctl_small", 64'(s_ctl), 64'(exp_ctl(0)));
        chk("ctl_big", 64'(b_ctl), 64'(exp_ctl(1)));
    endtask

    task automatic check_regs();
        chk("stall_small", 64'(s_stall), 64'(stl[0]));
        chk("flush_small", 64'(s_flush), 64'(fl[0]));
        chk("tmo_small", 64'(s_to), 64'(err[0]));
        chk("stall_big", 64'(b_stall), 64'(stl[1]));
        chk("flush_big", 64'(b_flush), 64'(fl[1]));
        chk("tmo_big", 64'(b_to), 64'(err[1]));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(bit l, bit b, bit q, bit r);
        lu = l; br = b; mreq = q; mrdy = r;
        #1 check_comb();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_regs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lu = 0; br = 0; mreq = 0; mrdy = 0;
        #1 model_reset();
        check_comb();
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        lu = 0; br = 0; mreq = 0; mrdy = 0;
        @(negedge clk);
        do_reset();

        // single load-use bubble
        step(1, 0, 0, 0);
        chk("lu_stall", 64'(b_stall), 64'd1);
        step(0, 0, 0, 0);

        // branch wins over load-use
        do_reset();
        step(1, 1, 0, 0);
        chk("br_lu_flush", 64'(b_flush), 64'd1);
        chk("br_lu_stall", 64'(b_stall), 64'd0);

        // three wait cycles then ready
        do_reset();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("wait3_stall", 64'(b_stall), 64'd3);
        step(0, 0, 0, 0);

        // stuck memory on MAX_WAIT=4 instance
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            chk("tmo_seq", 64'(s_to), 64'(i >= 4));
        end
        step(1, 1, 0, 1);
        chk("tmo_held", 64'(s_to), 64'd1);
        do_reset();
        chk("tmo_cleared", 64'(s_to), 64'd0);

        // load-use during a memory wait
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // reset abandons an access in progress
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        do_reset();
        step(0, 0, 0, 0);
        chk("rst_resume_pc", 64'(b_pc), 64'd1);

        // counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
        chk("sat_small", 64'(s_stall), 64'hF);
        chk("sat_big", 64'(b_stall), 64'd20);

        // randomized traffic with bursts of dead memory
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit r;
            r = ($urandom_range(0, 9) < 6);
            if ((i % 500) >= 200 && (i % 500) < 225) r = 0;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     bit'($urandom_range(0, 1)), r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
